// File: rtl/song_player_ctrl.sv
// Note-sequencer controller: walks a registered note ROM slot by slot, gating each
// note for the first part of its beat, with pause/resume, stop, looping and end-of-song signalling.
module song_player_ctrl #(
  parameter int SONG_LEN   = 48,
  parameter int ADDR_W     = 6,
  parameter int BEAT_TICKS = 100000000,
  parameter int GAP_TICKS  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [6:0]        rom_data,
  output logic [6:0]        note,
  output logic              note_gate,
  output logic              note_start,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (BEAT_TICKS > 2) ? $clog2(BEAT_TICKS) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BEAT_TICKS - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]    GATE_LIM  = (CNT_W + 1)'(BEAT_TICKS - GAP_TICKS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [6:0]        END_MARK  = 7'h7F;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_PLAY   = 3'd3,
    S_PAUSED = 3'd4
  } state_t;

  state_t            r_state, w_state;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [6:0]        r_note, w_note;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic              r_gate, w_gate;
  logic              r_start, w_start;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic              w_song_end;

  // Next-state and next-output decode; stop overrides everything outside IDLE.
  always_comb begin
    w_state    = r_state;
    w_addr     = r_addr;
    w_note     = r_note;
    w_cnt      = r_cnt;
    w_start    = 1'b0;
    w_done     = 1'b0;
    w_song_end = 1'b0;
    if (stop && (r_state != S_IDLE)) begin
      w_state = S_IDLE;
      w_addr  = ADDR_ZERO;
      w_note  = 7'd0;
      w_cnt   = CNT_ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (play) begin
            w_state = S_FETCH;
            w_addr  = ADDR_ZERO;
          end else begin
            w_state = S_IDLE;
          end
        end
        S_FETCH: w_state = S_LOAD;
        S_LOAD: begin
          if (rom_data == END_MARK) begin
            w_song_end = 1'b1;
          end else begin
            w_note  = rom_data;
            w_start = 1'b1;
            w_cnt   = CNT_ZERO;
            w_state = S_PLAY;
          end
        end
        S_PLAY: begin
          if (pause) begin
            w_state = S_PAUSED;
          end else if (r_cnt == LAST_CNT) begin
            if (r_addr == LAST_ADDR) begin
              w_song_end = 1'b1;
            end else begin
              w_addr  = r_addr + ADDR_ONE;
              w_state = S_FETCH;
            end
          end else begin
            w_cnt = r_cnt + CNT_ONE;
          end
        end
        S_PAUSED: begin
          if (play && !pause) begin
            w_state = S_PLAY;
          end else begin
            w_state = S_PAUSED;
          end
        end
        default: begin
          w_state = S_IDLE;
          w_addr  = ADDR_ZERO;
          w_note  = 7'd0;
          w_cnt   = CNT_ZERO;
        end
      endcase
      // End marker and last-slot expiry share the same wrap-or-finish handling.
      if (w_song_end) begin
        w_addr = ADDR_ZERO;
        if (loop_en) begin
          w_state = S_FETCH;
        end else begin
          w_state = S_IDLE;
          w_note  = 7'd0;
          w_done  = 1'b1;
        end
      end else begin
        w_done = 1'b0;
      end
    end
    w_gate = (w_state == S_PLAY) && (w_note != 7'd0) && ({1'b0, w_cnt} < GATE_LIM);
    w_busy = (w_state != S_IDLE);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_addr  <= ADDR_ZERO;
      r_note  <= 7'd0;
      r_cnt   <= CNT_ZERO;
      r_gate  <= 1'b0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_addr  <= w_addr;
      r_note  <= w_note;
      r_cnt   <= w_cnt;
      r_gate  <= w_gate;
      r_start <= w_start;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign rom_addr   = r_addr;
  assign note       = r_note;
  assign note_gate  = r_gate;
  assign note_start = r_start;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_song_player_ctrl.sv
// Self-checking bench for song_player_ctrl: directed vector table, corner-case
// sequences, and randomized commands against a slot/position reference model.
module tb_song_player_ctrl;

  localparam int SL = 4;
  localparam int AW = 2;
  localparam int BT = 8;
  localparam int GT = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          play = 1'b0, pause = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [6:0]    rom_data;
  logic [6:0]    note;
  logic          note_gate, note_start, busy, done;
  logic [6:0]    rom [SL];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Registered note ROM: data follows the address by one clock.
  always @(posedge clk) rom_data <= rom[rom_addr];

  song_player_ctrl #(
    .SONG_LEN(SL), .ADDR_W(AW), .BEAT_TICKS(BT), .GAP_TICKS(GT)
  ) dut (
    .clk(clk), .reset(reset), .play(play), .pause(pause), .stop(stop),
    .loop_en(loop_en), .rom_addr(rom_addr), .rom_data(rom_data), .note(note),
    .note_gate(note_gate), .note_start(note_start), .busy(busy), .done(done)
  );

  function automatic logic [31:0] pk(input logic [1:0] a, input logic [6:0] n,
                                     input logic g, input logic s, input logic b, input logic d);
    return {19'd0, a, n, g, s, b, d};
  endfunction

  function automatic logic [31:0] outs();
    return pk(rom_addr, note, note_gate, note_start, busy, done);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; play = 1'b0; pause = 1'b0; stop = 1'b0; loop_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic play_pulse();
    play = 1'b1;
    @(negedge clk);
    play = 1'b0;
  endtask

  typedef struct {
    logic       pl;
    logic [1:0] addr;
    logic [6:0] nt;
    logic       g, s, b, d;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(input logic pl, input logic [1:0] a, input logic [6:0] n,
                              input logic g, input logic s, input logic b, input logic d);
    vec_t v;
    v.pl = pl; v.addr = a; v.nt = n; v.g = g; v.s = s; v.b = b; v.d = d;
    return v;
  endfunction

  // Reference model: mode 0 idle, 1 running, 2 paused; pos 0 fetch, 1 load, 2.. beat position + 2.
  int         m_mode, m_pos, m_slot;
  logic [6:0] m_note;
  logic       m_start, m_done;

  task automatic m_end_song();
    m_slot = 0;
    m_pos  = 0;
    if (!loop_en) begin
      m_mode = 0;
      m_note = 7'd0;
      m_done = 1'b1;
    end
  endtask

  task automatic m_step();
    m_start = 1'b0;
    m_done  = 1'b0;
    if (m_mode == 0) begin
      if (play) begin m_mode = 1; m_slot = 0; m_pos = 0; end
    end else if (stop) begin
      m_mode = 0; m_slot = 0; m_pos = 0; m_note = 7'd0;
    end else if (m_mode == 2) begin
      if (play && !pause) m_mode = 1;
    end else if (m_pos == 0) begin
      m_pos = 1;
    end else if (m_pos == 1) begin
      if (rom[m_slot] == 7'h7F) m_end_song();
      else begin m_note = rom[m_slot]; m_start = 1'b1; m_pos = 2; end
    end else if (pause) begin
      m_mode = 2;
    end else if (m_pos == BT + 1) begin
      if (m_slot == SL - 1) m_end_song();
      else begin m_slot++; m_pos = 0; end
    end else begin
      m_pos++;
    end
  endtask

  function automatic logic [31:0] m_outs();
    logic g;
    g = (m_mode == 1) && (m_pos >= 2) && (m_note != 7'd0) && ((m_pos - 2) < (BT - GT));
    return pk(2'(m_slot), m_note, g, m_start, (m_mode != 0), m_done);
  endfunction

  initial begin
    int          k, done_k, done_n, rest_gate, starts, seen1, back0, found;
    logic [6:0]  notes_q [$];
    logic        exp_g [4];

    rom[0] = 7'd5; rom[1] = 7'd0; rom[2] = 7'd9; rom[3] = 7'd12;

    // Reset holds every output low.
    repeat (2) @(negedge clk);
    chk("reset_outs", outs(), pk(2'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    reset = 1'b1;
    @(negedge clk);

    // Directed table: first slot and start of the second (rest) slot.
    tbl[0]  = mk(1'b1, 2'd0, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[1]  = mk(1'b0, 2'd0, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[2]  = mk(1'b0, 2'd0, 7'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 3; i < 8; i++) tbl[i] = mk(1'b0, 2'd0, 7'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[8]  = mk(1'b0, 2'd0, 7'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[9]  = mk(1'b0, 2'd0, 7'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[10] = mk(1'b0, 2'd1, 7'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[11] = mk(1'b0, 2'd1, 7'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[12] = mk(1'b0, 2'd1, 7'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 13; i++) begin
      play = tbl[i].pl;
      @(negedge clk);
      chk($sformatf("vec%0d", i), outs(),
          pk(tbl[i].addr, tbl[i].nt, tbl[i].g, tbl[i].s, tbl[i].b, tbl[i].d));
    end

    // Full song without loop.
    do_reset();
    play_pulse();
    done_k = -1; done_n = 0; rest_gate = 0; notes_q.delete();
    for (int e = 0; e < 60; e++) begin
      if (note_start) notes_q.push_back(note);
      if (note_gate && note == 7'd0) rest_gate++;
      if (done) begin done_n++; done_k = e; end
      if (e < 59) @(negedge clk);
    end
    chk("song_len", 32'(notes_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("song_note%0d", i), (i < notes_q.size()) ? 32'(notes_q[i]) : 32'hFFFF, 32'(rom[i]));
    chk("rest_gate", 32'(rest_gate), 32'd0);
    chk("done_count", 32'(done_n), 32'd1);
    chk("done_edge", 32'(done_k), 32'd40);
    chk("after_done", {30'd0, busy, (note != 7'd0)}, 32'd0);

    // Pause on beat 3 of note 9, hold 20 cycles, resume.
    do_reset();
    play_pulse();
    found = 0;
    for (int e = 0; e < 40 && found == 0; e++) begin
      if (note_start && note == 7'd9) found = 1;
      else @(negedge clk);
    end
    chk("pause_found9", 32'(found), 32'd1);
    repeat (3) @(negedge clk);
    pause = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      chk($sformatf("paused%0d", j), outs(), pk(2'd2, 7'd9, 1'b0, 1'b0, 1'b1, 1'b0));
    end
    pause = 1'b0; play = 1'b1;
    @(negedge clk);
    play = 1'b0;
    chk("resume", outs(), pk(2'd2, 7'd9, 1'b1, 1'b0, 1'b1, 1'b0));
    exp_g[0] = 1'b1; exp_g[1] = 1'b1; exp_g[2] = 1'b0; exp_g[3] = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (j < 4) chk($sformatf("resume_tail%0d", j), outs(), pk(2'd2, 7'd9, exp_g[j], 1'b0, 1'b1, 1'b0));
      else chk("resume_next_slot", {30'd0, rom_addr}, 32'd3);
    end

    // Stop and pause together while playing.
    do_reset();
    play_pulse();
    repeat (5) @(negedge clk);
    stop = 1'b1; pause = 1'b1;
    @(negedge clk);
    stop = 1'b0; pause = 1'b0;
    chk("stop_pause", outs(), pk(2'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    chk("stop_stays_idle", outs(), pk(2'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Asynchronous reset between edges while playing.
    do_reset();
    play_pulse();
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", {30'd0, busy, note_gate}, 32'd3);
    #2 reset = 1'b0;
    #1 chk("async_reset", outs(), pk(2'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    reset = 1'b1;
    play_pulse();
    @(negedge clk);
    chk("rst_replay_e1", outs(), pk(2'd0, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    chk("rst_replay_e2", outs(), pk(2'd0, 7'd5, 1'b1, 1'b1, 1'b1, 1'b0));

    // End marker with looping.
    do_reset();
    rom[0] = 7'd5; rom[1] = 7'h7F; rom[2] = 7'd3; rom[3] = 7'd4;
    loop_en = 1'b1;
    play_pulse();
    starts = 0; done_n = 0; seen1 = 0; back0 = 0; k = 0;
    for (int e = 0; e < 60; e++) begin
      if (note_start) begin
        starts++;
        if (note != 7'd5) k++;
      end
      if (done) done_n++;
      if (rom_addr == 2'd1) seen1 = 1;
      if (seen1 == 1 && rom_addr == 2'd0) back0 = 1;
      if (e < 59) @(negedge clk);
    end
    chk("loop_starts", 32'(starts), 32'd5);
    chk("loop_wrong_note", 32'(k), 32'd0);
    chk("loop_done", 32'(done_n), 32'd0);
    chk("loop_addr_wrap", 32'(back0), 32'd1);

    // Randomized commands against the reference model.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < SL; i++)
        rom[i] = ($urandom_range(0, 4) == 0) ? 7'h7F : 7'($urandom_range(0, 126));
      m_mode = 0; m_pos = 0; m_slot = 0; m_note = 7'd0; m_start = 1'b0; m_done = 1'b0;
      for (int c = 0; c < 800; c++) begin
        play    = ($urandom_range(0, 3) == 0);
        pause   = ($urandom_range(0, 15) == 0);
        stop    = ($urandom_range(0, 127) == 0);
        if ($urandom_range(0, 63) == 0) loop_en = ~loop_en;
        @(posedge clk);
        m_step();
        @(negedge clk);
        chk($sformatf("rand%0d_%0d", r, c), outs(), m_outs());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
